// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state encoding, opcode/ALU/mux constants and control-word layout
// shared by control_unit and ctrl_decode.
package ctrl_pkg;

   localparam int ST_BITS = 5;

   typedef enum logic [ST_BITS-1:0] {
      S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU, S_ADDR, S_MEM_RD,
      S_LD_WB, S_MEM_WR, S_BRANCH, S_LUI, S_HALT, S_ILLEGAL, S_EXC
   } state_t;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_SD  = 7'b0100011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_SYS = 7'b1110011;

   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;
   localparam logic [2:0] F3_AND = 3'b111;

   localparam logic [2:0] ALU_LOAD = 3'd0;
   localparam logic [2:0] ALU_ADD  = 3'd1;
   localparam logic [2:0] ALU_SUB  = 3'd2;
   localparam logic [2:0] ALU_AND  = 3'd3;

   localparam logic [1:0] PC_ALU    = 2'd0;
   localparam logic [1:0] PC_ALUOUT = 2'd1;
`ifdef CTRL_EXCEPTION_EN
   localparam logic [1:0] PC_EXC    = 2'd2;
`endif

   localparam logic       ULA_A_PC   = 1'b0;
   localparam logic       ULA_A_REG  = 1'b1;
   localparam logic [1:0] ULA_B_REG  = 2'd0;
   localparam logic [1:0] ULA_B_FOUR = 2'd1;
   localparam logic [1:0] ULA_B_IMM  = 2'd2;

   localparam logic [1:0] WB_ALUOUT = 2'd0;
   localparam logic [1:0] WB_MDR    = 2'd1;
   localparam logic [1:0] WB_IMM    = 2'd2;

   typedef struct packed {
      logic       load_pc;
      logic [1:0] sel_mux_pc;
      logic       load_ir;
      logic       write_a;
      logic       write_b;
      logic       write_aluout;
      logic       write_epc;
      logic       sel_ula_a;
      logic [1:0] sel_ula_b;
      logic [2:0] alu_op;
      logic       mem_addr_sel;
      logic       mem_we;
      logic       reg_write;
      logic [1:0] wb_sel;
      logic       halted;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

   function automatic logic branch_taken(input logic [2:0] f3, input logic eq);
      return (f3 == F3_BEQ && eq) || (f3 == F3_BNE && !eq);
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational state -> control-word table for control_unit.
// Exception outputs exist only when CTRL_EXCEPTION_EN is defined.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [ST_BITS-1:0] i_state,
   input  logic              i_run,
   input  logic              i_done,
   input  logic [2:0]        i_funct3,
   input  logic              i_funct7b5,
   input  logic              i_igual,
   output logic [CTRL_W-1:0] o_ctrl
);

   state_t w_state;
   ctrl_t  w_c;

   assign w_state = state_t'(i_state);
   assign o_ctrl  = w_c;

   // i_run is the raw reset pin, so every strobe drops the moment reset asserts
   always_comb begin
      w_c        = '0;
      w_c.alu_op = ALU_LOAD;
      if (i_run)
         case (w_state)
            S_FETCH:
               if (i_done) begin
                  w_c.load_ir    = 1'b1;
                  w_c.load_pc    = 1'b1;
                  w_c.sel_mux_pc = PC_ALU;
                  w_c.sel_ula_a  = ULA_A_PC;
                  w_c.sel_ula_b  = ULA_B_FOUR;
                  w_c.alu_op     = ALU_ADD;
               end
            S_DECODE: begin
               w_c.write_a      = 1'b1;
               w_c.write_b      = 1'b1;
               w_c.write_aluout = 1'b1;
               w_c.sel_ula_a    = ULA_A_PC;
               w_c.sel_ula_b    = ULA_B_IMM;
               w_c.alu_op       = ALU_ADD;
            end
            S_EXEC_R: begin
               w_c.write_aluout = 1'b1;
               w_c.sel_ula_a    = ULA_A_REG;
               w_c.sel_ula_b    = ULA_B_REG;
               w_c.alu_op       = (i_funct3 == F3_AND) ? ALU_AND : i_funct7b5 ? ALU_SUB : ALU_ADD;
            end
            S_EXEC_I, S_ADDR: begin
               w_c.write_aluout = 1'b1;
               w_c.sel_ula_a    = ULA_A_REG;
               w_c.sel_ula_b    = ULA_B_IMM;
               w_c.alu_op       = ALU_ADD;
            end
            S_WB_ALU: begin
               w_c.reg_write = 1'b1;
               w_c.wb_sel    = WB_ALUOUT;
            end
            S_MEM_RD: w_c.mem_addr_sel = 1'b1;
            S_LD_WB: begin
               w_c.reg_write = 1'b1;
               w_c.wb_sel    = WB_MDR;
            end
            S_MEM_WR: begin
               w_c.mem_addr_sel = 1'b1;
               w_c.mem_we       = 1'b1;
            end
            S_BRANCH: begin
               w_c.sel_ula_a  = ULA_A_REG;
               w_c.sel_ula_b  = ULA_B_REG;
               w_c.alu_op     = ALU_SUB;
               w_c.load_pc    = branch_taken(i_funct3, i_igual);
               w_c.sel_mux_pc = branch_taken(i_funct3, i_igual) ? PC_ALUOUT : PC_ALU;
            end
            S_LUI: begin
               w_c.reg_write = 1'b1;
               w_c.wb_sel    = WB_IMM;
            end
            S_HALT: w_c.halted = 1'b1;
`ifdef CTRL_EXCEPTION_EN
            // EPC gets PC-4: PC was already advanced during FETCH
            S_EXC: begin
               w_c.write_epc  = 1'b1;
               w_c.load_pc    = 1'b1;
               w_c.sel_mux_pc = PC_EXC;
               w_c.sel_ula_a  = ULA_A_PC;
               w_c.sel_ula_b  = ULA_B_FOUR;
               w_c.alu_op     = ALU_SUB;
            end
`endif
            default: ;
         endcase
   end

endmodule

// File: rtl/control_unit.sv
// control_unit: multicycle RISC-V control FSM with memory wait counter.
// Define CTRL_EXCEPTION_EN to trap illegal opcodes and ALU overflow into EXC.
module control_unit
   import ctrl_pkg::*;
#(
   parameter int MEM_WAIT = 1,
   parameter int ST_W     = 5
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       igual,
   input  logic       overflow,
   output logic       load_pc,
   output logic [1:0] sel_mux_pc,
   output logic       load_ir,
   output logic       write_a,
   output logic       write_b,
   output logic       write_aluout,
   output logic       write_epc,
   output logic       sel_ula_a,
   output logic [1:0] sel_ula_b,
   output logic [2:0] alu_op,
   output logic       mem_addr_sel,
   output logic       mem_we,
   output logic       reg_write,
   output logic [1:0] wb_sel,
   output logic       halted
);

   logic [ST_W-1:0]   r_state;
   logic [3:0]        r_cnt;
   state_t            w_state;
   state_t            w_next;
   logic              w_done;
   logic [CTRL_W-1:0] w_ctrl;
   ctrl_t             w_c;

   assign w_state = state_t'(r_state[ST_BITS-1:0]);
   assign w_done  = r_cnt == 4'(MEM_WAIT);

   // counter restarts on every state change and saturates at MEM_WAIT
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_state <= ST_W'(S_FETCH);
         r_cnt   <= '0;
      end else begin
         r_state <= ST_W'(w_next);
         r_cnt   <= (w_next != w_state) ? '0 : r_cnt + {3'b0, !w_done};
      end

   always_comb begin
      w_next = w_state;
      case (w_state)
         S_FETCH:  w_next = w_done ? S_DECODE : S_FETCH;
         S_DECODE:
            case (opcode)
               OP_R:         w_next = S_EXEC_R;
               OP_I:         w_next = S_EXEC_I;
               OP_LD, OP_SD: w_next = S_ADDR;
               OP_BR:        w_next = S_BRANCH;
               OP_LUI:       w_next = S_LUI;
               OP_SYS:       w_next = S_HALT;
               default:      w_next = S_ILLEGAL;
            endcase
`ifdef CTRL_EXCEPTION_EN
         S_EXEC_R, S_EXEC_I: w_next = overflow ? S_EXC : S_WB_ALU;
         S_ILLEGAL:          w_next = S_EXC;
`else
         S_EXEC_R, S_EXEC_I: w_next = S_WB_ALU;
         S_ILLEGAL:          w_next = S_HALT;
`endif
         S_ADDR:   w_next = (opcode == OP_LD) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD: w_next = w_done ? S_LD_WB : S_MEM_RD;
         S_MEM_WR: w_next = w_done ? S_FETCH : S_MEM_WR;
         S_HALT:   w_next = S_HALT;
         default:  w_next = S_FETCH;
      endcase
   end

`ifndef CTRL_EXCEPTION_EN
   logic w_unused;
   assign w_unused = overflow;
`endif

   ctrl_decode u_decode (
      .i_state    (w_state),
      .i_run      (reset),
      .i_done     (w_done),
      .i_funct3   (funct3),
      .i_funct7b5 (funct7b5),
      .i_igual    (igual),
      .o_ctrl     (w_ctrl)
   );

   assign w_c          = ctrl_t'(w_ctrl);
   assign load_pc      = w_c.load_pc;
   assign sel_mux_pc   = w_c.sel_mux_pc;
   assign load_ir      = w_c.load_ir;
   assign write_a      = w_c.write_a;
   assign write_b      = w_c.write_b;
   assign write_aluout = w_c.write_aluout;
   assign write_epc    = w_c.write_epc;
   assign sel_ula_a    = w_c.sel_ula_a;
   assign sel_ula_b    = w_c.sel_ula_b;
   assign alu_op       = w_c.alu_op;
   assign mem_addr_sel = w_c.mem_addr_sel;
   assign mem_we       = w_c.mem_we;
   assign reg_write    = w_c.reg_write;
   assign wb_sel       = w_c.wb_sel;
   assign halted       = w_c.halted;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: two control units (MEM_WAIT 0 and 2) driven by random
// instruction streams, each checked every cycle against a micro-step plan model.
module tb_control_unit;

   localparam int S_FW = 0, S_FF = 1, S_DEC = 2, S_EXR = 3, S_EXI = 4, S_WB = 5, S_ADDR = 6,
                  S_RD = 7, S_LDWB = 8, S_WR = 9, S_BR = 10, S_LUI = 11, S_HALT = 12,
                  S_ILL = 13, S_EXC = 14;

   typedef struct packed {
      logic       load_pc;
      logic [1:0] sel_mux_pc;
      logic       load_ir;
      logic       write_a;
      logic       write_b;
      logic       write_aluout;
      logic       write_epc;
      logic       sel_ula_a;
      logic [1:0] sel_ula_b;
      logic [2:0] alu_op;
      logic       mem_addr_sel;
      logic       mem_we;
      logic       reg_write;
      logic [1:0] wb_sel;
      logic       halted;
   } outs_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d @%0t: got %0h, expected %0h", name, d, $time, act, exp);
      end
   endtask

   // ALU codes: LOAD 0, ADD 1, SUB 2, AND 3
   function automatic outs_t expect_outs(input int s, input logic [2:0] f3, input logic f7, input logic eq);
      outs_t o;
      o = '0;
      case (s)
         S_FF:   begin o.load_ir = 1; o.load_pc = 1; o.sel_ula_b = 1; o.alu_op = 1; end
         S_DEC:  begin o.write_a = 1; o.write_b = 1; o.write_aluout = 1; o.sel_ula_b = 2; o.alu_op = 1; end
         S_EXR:  begin o.write_aluout = 1; o.sel_ula_a = 1; o.alu_op = (f3 == 3'b111) ? 3 : (f7 ? 2 : 1); end
         S_EXI, S_ADDR: begin o.write_aluout = 1; o.sel_ula_a = 1; o.sel_ula_b = 2; o.alu_op = 1; end
         S_WB:   o.reg_write = 1;
         S_RD:   o.mem_addr_sel = 1;
         S_LDWB: begin o.reg_write = 1; o.wb_sel = 1; end
         S_WR:   begin o.mem_we = 1; o.mem_addr_sel = 1; end
         S_BR: begin
            o.sel_ula_a = 1;
            o.alu_op = 2;
            if ((f3 == 3'b000 && eq) || (f3 == 3'b001 && !eq)) begin o.load_pc = 1; o.sel_mux_pc = 1; end
         end
         S_LUI:  begin o.reg_write = 1; o.wb_sel = 2; end
         S_HALT: o.halted = 1;
         S_EXC:  begin o.write_epc = 1; o.load_pc = 1; o.sel_mux_pc = 2; o.sel_ula_b = 1; o.alu_op = 2; end
         default: ;
      endcase
      return o;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_m
      localparam int MW = (g == 0) ? 0 : 2;
      logic [6:0] opcode;
      logic [2:0] funct3;
      logic       funct7b5, igual, overflow;
      logic       load_pc, load_ir, write_a, write_b, write_aluout, write_epc, sel_ula_a;
      logic       mem_addr_sel, mem_we, reg_write, halted;
      logic [1:0] sel_mux_pc, sel_ula_b, wb_sel;
      logic [2:0] alu_op;
      outs_t      act;

      control_unit #(.MEM_WAIT(MW)) dut (
         .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
         .igual(igual), .overflow(overflow), .load_pc(load_pc), .sel_mux_pc(sel_mux_pc),
         .load_ir(load_ir), .write_a(write_a), .write_b(write_b), .write_aluout(write_aluout),
         .write_epc(write_epc), .sel_ula_a(sel_ula_a), .sel_ula_b(sel_ula_b), .alu_op(alu_op),
         .mem_addr_sel(mem_addr_sel), .mem_we(mem_we), .reg_write(reg_write), .wb_sel(wb_sel),
         .halted(halted)
      );

      assign act = {load_pc, sel_mux_pc, load_ir, write_a, write_b, write_aluout, write_epc,
                    sel_ula_a, sel_ula_b, alu_op, mem_addr_sel, mem_we, reg_write, wb_sel, halted};

      // plan: queue of upcoming micro-steps; cur: step the DUT is in this cycle
      initial begin
         int    plan[$];
         int    cur;
         int    run;
         int    r;
         bit    new_instr;
         outs_t e;
         cur = S_FW; run = 0; new_instr = 1'b1;
         opcode = '0; funct3 = '0; funct7b5 = 1'b0; igual = 1'b0; overflow = 1'b0;
         forever begin
            @(posedge clk);
            #1;
            igual    = 1'($urandom);
            overflow = ($urandom_range(0, 3) == 0);
            if (new_instr) begin
               new_instr = 1'b0;
               r = $urandom_range(0, 199);
               funct3   = 3'($urandom_range(0, 7));
               funct7b5 = 1'($urandom);
               if (r < 2) opcode = 7'b1110011;
               else if (r < 5) opcode = r[0] ? 7'b0000000 : 7'b1111111;
               else if (r < 45) begin
                  opcode = 7'b0110011;
                  if (r < 25) funct3 = r[0] ? 3'b000 : 3'b111;
               end
               else if (r < 75) opcode = 7'b0010011;
               else if (r < 105) opcode = 7'b0000011;
               else if (r < 135) opcode = 7'b0100011;
               else if (r < 175) begin
                  opcode = 7'b1100011;
                  funct3 = 3'($urandom_range(0, 2));
               end
               else opcode = 7'b0110111;
            end
            @(negedge clk);
            e = reset ? expect_outs(cur, funct3, funct7b5, igual) : '0;
            check("outputs", g, 32'(act), 32'(e));
            check("one_strobe", g, 32'($countones({load_pc, reg_write, mem_we}) <= 1), 1);
            if (!reset) run = 0;
            else if (mem_addr_sel) run++;
            else if (run > 0) begin
               check("mem_addr_sel_run", g, run, MW + 1);
               run = 0;
            end
            if (!reset) plan.delete();
            else if (cur != S_HALT) begin
               if (cur == S_FF) new_instr = 1'b1;
               case (cur)
                  S_DEC:
                     case (opcode)
                        7'b0110011: begin plan.push_back(S_EXR); plan.push_back(S_WB); end
                        7'b0010011: begin plan.push_back(S_EXI); plan.push_back(S_WB); end
                        7'b0000011, 7'b0100011: plan.push_back(S_ADDR);
                        7'b1100011: plan.push_back(S_BR);
                        7'b0110111: plan.push_back(S_LUI);
                        7'b1110011: plan.push_back(S_HALT);
                        default:    plan.push_back(S_ILL);
                     endcase
                  S_ADDR: begin
                     for (int i = 0; i <= MW; i++) plan.push_back(opcode == 7'b0000011 ? S_RD : S_WR);
                     if (opcode == 7'b0000011) plan.push_back(S_LDWB);
                  end
`ifdef CTRL_EXCEPTION_EN
                  S_EXR, S_EXI: if (overflow) begin plan.delete(); plan.push_back(S_EXC); end
                  S_ILL: plan.push_back(S_EXC);
`else
                  S_ILL: plan.push_back(S_HALT);
`endif
                  default: ;
               endcase
            end
            if (!reset || cur != S_HALT) begin
               if (plan.size() == 0) begin
                  for (int i = 0; i < MW; i++) plan.push_back(S_FW);
                  plan.push_back(S_FF);
                  plan.push_back(S_DEC);
               end
               cur = plan.pop_front();
            end
         end
      end
   end

   initial begin
      int lat0, lat1;
      lat0 = 0; lat1 = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", 0, 32'(g_m[0].act), 0);
      check("reset_outputs", 1, 32'(g_m[1].act), 0);
      reset = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (lat0 == 0 && g_m[0].load_ir) lat0 = k;
         if (lat1 == 0 && g_m[1].load_ir) lat1 = k;
      end
      check("first_load_ir_cycle", 0, lat0, 1);
      check("first_load_ir_cycle", 1, lat1, 3);
      for (int s = 0; s < 10; s++) begin
         repeat ($urandom_range(300, 450)) @(posedge clk);
         #1 reset = 1'b0;
         #1;
         check("async_reset_outputs", 0, 32'(g_m[0].act), 0);
         check("async_reset_outputs", 1, 32'(g_m[1].act), 0);
         repeat (2) @(posedge clk);
         #1 reset = 1'b1;
      end
      repeat (20) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
